// File: rtl/ntt_pkg.sv
// Shared widths, twiddle-mode encodings and controller state type for the
// inverse-NTT datapath and its sequencer.
package ntt_pkg;

    localparam int ADDR_W   = 9;
    localparam int TW_IDX_W = 12;
    localparam int LOG_M_W  = 4;
    localparam int I_W      = 10;

    localparam logic [1:0] MODE_ADDR  = 2'd0;
    localparam logic [1:0] MODE_GROUP = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } ctrl_state_e;

    // Twiddle addressing mode for a stage of size 2^log_m.
    function automatic logic [1:0] mode_for(input logic [LOG_M_W-1:0] log_m,
                                            input int log_n,
                                            input int log_core_count);
        int lm;
        lm = int'(log_m);
        if (lm == log_n) return MODE_ADDR;
        if ((lm > log_core_count + 1) && (lm < log_n)) return MODE_GROUP;
        return MODE_CONST;
    endfunction

endpackage

// File: rtl/intt_controller_if.sv
// Command and intt_core control bundle driven by intt_controller (master).
interface intt_controller_if;
    import ntt_pkg::*;

    logic               start;
    logic               direct_first;
    logic               busy;
    logic               done;
    logic               result_select;
    logic [LOG_M_W-1:0] log_m;
    logic [I_W-1:0]     i;
    logic [1:0]         mode;
    logic [ADDR_W-1:0]  upper_read_address;
    logic [ADDR_W-1:0]  lower_read_address;
    logic [ADDR_W-1:0]  upper_write_address;
    logic [ADDR_W-1:0]  lower_write_address;
    logic               upper_write_enable;
    logic               lower_write_enable;
    logic               read_select;
    logic               write_select;
    logic               input_select;

    modport master (
        input  start, direct_first,
        output busy, done, result_select, log_m, i, mode,
               upper_read_address, lower_read_address,
               upper_write_address, lower_write_address,
               upper_write_enable, lower_write_enable,
               read_select, write_select, input_select
    );

    modport slave (
        output start, direct_first,
        input  busy, done, result_select, log_m, i, mode,
               upper_read_address, lower_read_address,
               upper_write_address, lower_write_address,
               upper_write_enable, lower_write_enable,
               read_select, write_select, input_select
    );

endinterface

// File: rtl/intt_ctrl_delay.sv
// Fixed-latency shift register that turns issued read addresses into
// write-back addresses once the butterfly pipeline has produced its result.
module intt_ctrl_delay
    import ntt_pkg::*;
#(
    parameter int LATENCY = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr
);

    logic [LATENCY-1:0]             valid_q, valid_d;
    logic [LATENCY-1:0][ADDR_W-1:0] addr_q,  addr_d;

    always_comb begin
        valid_d[0] = in_valid;
        addr_d[0]  = in_addr;
        for (int k = 1; k < LATENCY; k++) begin
            valid_d[k] = valid_q[k-1];
            addr_d[k]  = addr_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_addr  = addr_q[LATENCY-1];

endmodule

// File: rtl/intt_controller.sv
// Stage sequencer for one inverse-NTT lane: walks all Gentleman-Sande stages,
// issues read/write-back addresses and ping-pongs the core_ram banks.
module intt_controller
    import ntt_pkg::*;
#(
    parameter int LOG_N          = 12,
    parameter int LOG_CORE_COUNT = 4,
    parameter int PIPE_LATENCY   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    intt_controller_if.master bus
);

    localparam int                 DEPTH      = 2 ** (LOG_N - LOG_CORE_COUNT - 2);
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [3:0]         LAST_DRAIN = 4'(PIPE_LATENCY - 1);
    localparam logic [LOG_M_W-1:0] LAST_STAGE = LOG_M_W'(LOG_N - 1);
    localparam logic [LOG_M_W-1:0] LOG_N_M    = LOG_M_W'(LOG_N);

    ctrl_state_e        state_q, state_d;
    logic [LOG_M_W-1:0] stage_q, stage_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [3:0]         drain_q, drain_d;
    logic               read_select_q, read_select_d;
    logic               write_select_q, write_select_d;
    logic               input_select_q, input_select_d;
    logic               result_select_q, result_select_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [LOG_M_W-1:0] log_m_q, log_m_d;
    logic [1:0]         mode_q, mode_d;
    logic [I_W-1:0]     i_q, i_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               rd_valid_q, rd_valid_d;
    logic               run_d, active_d;
    logic               wr_valid;
    logic [ADDR_W-1:0]  wr_addr;

    always_comb begin
        state_d         = state_q;
        stage_d         = stage_q;
        addr_d          = addr_q;
        drain_d         = drain_q;
        read_select_d   = read_select_q;
        write_select_d  = write_select_q;
        input_select_d  = input_select_q;
        result_select_d = result_select_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d        = ST_RUN;
                    stage_d        = '0;
                    addr_d         = '0;
                    read_select_d  = 1'b0;
                    write_select_d = 1'b1;
                    input_select_d = bus.direct_first;
                end
            end
            ST_RUN: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d         = ST_DONE;
                        result_select_d = write_select_q;
                    end else begin
                        state_d        = ST_RUN;
                        stage_d        = stage_q + 1'b1;
                        addr_d         = '0;
                        read_select_d  = ~read_select_q;
                        write_select_d = ~write_select_q;
                        input_select_d = 1'b0;
                    end
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next-state values so every port is a flop.
        run_d      = (state_d == ST_RUN);
        active_d   = run_d || (state_d == ST_DRAIN);
        busy_d     = active_d;
        done_d     = (state_d == ST_DONE);
        log_m_d    = active_d ? (LOG_N_M - stage_d) : '0;
        mode_d     = active_d ? mode_for(log_m_d, LOG_N, LOG_CORE_COUNT) : MODE_ADDR;
        i_d        = (run_d && (mode_d == MODE_GROUP)) ? I_W'(addr_d >> stage_d) : '0;
        rd_addr_d  = run_d ? addr_d : '0;
        rd_valid_d = run_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            stage_q         <= '0;
            addr_q          <= '0;
            drain_q         <= '0;
            read_select_q   <= 1'b0;
            write_select_q  <= 1'b0;
            input_select_q  <= 1'b0;
            result_select_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            log_m_q         <= '0;
            mode_q          <= '0;
            i_q             <= '0;
            rd_addr_q       <= '0;
            rd_valid_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            stage_q         <= stage_d;
            addr_q          <= addr_d;
            drain_q         <= drain_d;
            read_select_q   <= read_select_d;
            write_select_q  <= write_select_d;
            input_select_q  <= input_select_d;
            result_select_q <= result_select_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            log_m_q         <= log_m_d;
            mode_q          <= mode_d;
            i_q             <= i_d;
            rd_addr_q       <= rd_addr_d;
            rd_valid_q      <= rd_valid_d;
        end
    end

    intt_ctrl_delay #(
        .LATENCY (PIPE_LATENCY)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_valid_q),
        .in_addr   (rd_addr_q),
        .out_valid (wr_valid),
        .out_addr  (wr_addr)
    );

    assign bus.busy                = busy_q;
    assign bus.done                = done_q;
    assign bus.result_select       = result_select_q;
    assign bus.log_m               = log_m_q;
    assign bus.i                   = i_q;
    assign bus.mode                = mode_q;
    assign bus.upper_read_address  = rd_addr_q;
    assign bus.lower_read_address  = rd_addr_q;
    assign bus.upper_write_address = wr_addr;
    assign bus.lower_write_address = wr_addr;
    assign bus.upper_write_enable  = wr_valid;
    assign bus.lower_write_enable  = wr_valid;
    assign bus.read_select         = read_select_q;
    assign bus.write_select        = write_select_q;
    assign bus.input_select        = input_select_q;

endmodule

// File: tb/tb_intt_controller.sv
// Directed bench for intt_controller with LOG_N=6, LOG_CORE_COUNT=1,
// PIPE_LATENCY=3 (DEPTH=8, 11 cycles per stage).
module tb_intt_controller;
    import ntt_pkg::*;

    localparam int LOG_N = 6;
    localparam int LCC   = 1;
    localparam int PL    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    intt_controller_if bus();

    intt_controller #(
        .LOG_N          (LOG_N),
        .LOG_CORE_COUNT (LCC),
        .PIPE_LATENCY   (PL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;
        logic       busy;
        logic [3:0] log_m;
        logic [1:0] mode;
        logic [9:0] i;
        logic [8:0] rd;
        logic       we;
        logic [8:0] wa;
        logic       rs;
        logic       ws;
        logic       is;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int cyc, input int busy, input int lm, input int mode,
                                input int i, input int rd, input int we, input int wa,
                                input int rs, input int ws, input int is);
        vec_t v;
        v.cyc   = cyc;
        v.busy  = busy[0];
        v.log_m = lm[3:0];
        v.mode  = mode[1:0];
        v.i     = i[9:0];
        v.rd    = rd[8:0];
        v.we    = we[0];
        v.wa    = wa[8:0];
        v.rs    = rs[0];
        v.ws    = ws[0];
        v.is    = is[0];
        return v;
    endfunction

    task automatic check_vec(input vec_t e);
        string p;
        p = $sformatf("c%0d_", e.cyc);
        chk({p, "busy"},  bus.busy,                e.busy);
        chk({p, "done"},  bus.done,                1'b0);
        chk({p, "log_m"}, bus.log_m,               e.log_m);
        chk({p, "mode"},  bus.mode,                e.mode);
        chk({p, "i"},     bus.i,                   e.i);
        chk({p, "rd"},    bus.upper_read_address,  e.rd);
        chk({p, "we"},    bus.upper_write_enable,  e.we);
        chk({p, "wa"},    bus.upper_write_address, e.wa);
        chk({p, "rs"},    bus.read_select,         e.rs);
        chk({p, "ws"},    bus.write_select,        e.ws);
        chk({p, "is"},    bus.input_select,        e.is);
    endtask

    task automatic check_all_zero(input string p);
        chk({p, "busy"},  bus.busy,                1'b0);
        chk({p, "done"},  bus.done,                1'b0);
        chk({p, "res"},   bus.result_select,       1'b0);
        chk({p, "log_m"}, bus.log_m,               4'd0);
        chk({p, "i"},     bus.i,                   10'd0);
        chk({p, "rd"},    bus.upper_read_address,  9'd0);
        chk({p, "we"},    bus.upper_write_enable,  1'b0);
        chk({p, "wa"},    bus.upper_write_address, 9'd0);
        chk({p, "rs"},    bus.read_select,         1'b0);
        chk({p, "ws"},    bus.write_select,        1'b0);
        chk({p, "is"},    bus.input_select,        1'b0);
    endtask

    initial begin
        int idx;
        int busy_cnt;
        int done_cnt;
        int done_cyc;
        int pair_bad;
        int done_in_reset;
        int got;

        //         cyc busy lm mode i rd we wa rs ws is
        tbl.push_back(mk( 1, 1, 6, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk( 3, 1, 6, 0, 0, 2, 0, 0, 0, 1, 1));
        tbl.push_back(mk( 4, 1, 6, 0, 0, 3, 1, 0, 0, 1, 1));
        tbl.push_back(mk( 8, 1, 6, 0, 0, 7, 1, 4, 0, 1, 1));
        tbl.push_back(mk( 9, 1, 6, 0, 0, 0, 1, 5, 0, 1, 1));
        tbl.push_back(mk(11, 1, 6, 0, 0, 0, 1, 7, 0, 1, 1));
        tbl.push_back(mk(12, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(13, 1, 5, 1, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(14, 1, 5, 1, 1, 2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(15, 1, 5, 1, 1, 3, 1, 0, 1, 0, 0));
        tbl.push_back(mk(16, 1, 5, 1, 2, 4, 1, 1, 1, 0, 0));
        tbl.push_back(mk(17, 1, 5, 1, 2, 5, 1, 2, 1, 0, 0));
        tbl.push_back(mk(18, 1, 5, 1, 3, 6, 1, 3, 1, 0, 0));
        tbl.push_back(mk(19, 1, 5, 1, 3, 7, 1, 4, 1, 0, 0));
        tbl.push_back(mk(20, 1, 5, 1, 0, 0, 1, 5, 1, 0, 0));
        tbl.push_back(mk(22, 1, 5, 1, 0, 0, 1, 7, 1, 0, 0));
        tbl.push_back(mk(23, 1, 4, 1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(28, 1, 4, 1, 1, 5, 1, 2, 0, 1, 0));
        tbl.push_back(mk(34, 1, 3, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(41, 1, 3, 1, 0, 7, 1, 4, 1, 0, 0));
        tbl.push_back(mk(45, 1, 2, 2, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(47, 1, 2, 2, 0, 2, 0, 0, 0, 1, 0));
        tbl.push_back(mk(56, 1, 1, 2, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(63, 1, 1, 2, 0, 7, 1, 4, 1, 0, 0));
        tbl.push_back(mk(66, 1, 1, 2, 0, 0, 1, 7, 1, 0, 0));

        bus.start        = 1'b0;
        bus.direct_first = 1'b0;

        // Reset state.
        tick();
        tick();
        check_all_zero("reset_");
        chk("reset_mode", bus.mode, 2'd0);
        #2 rst_n = 1'b1;
        tick();

        // Full transform with direct_first=1 and a stray start at cycle 20.
        bus.start        = 1'b1;
        bus.direct_first = 1'b1;
        idx      = 0;
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        pair_bad = 0;
        for (int c = 1; c <= 70; c++) begin
            tick();
            bus.start        = (c == 20);
            bus.direct_first = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_cyc = c;
            end
            if ((bus.upper_read_address  !== bus.lower_read_address) ||
                (bus.upper_write_address !== bus.lower_write_address) ||
                (bus.upper_write_enable  !== bus.lower_write_enable) ||
                (bus.busy && (bus.write_select === bus.read_select)))
                pair_bad++;
            while (idx < tbl.size() && tbl[idx].cyc == c) begin
                check_vec(tbl[idx]);
                idx++;
            end
            if (c == 67) begin
                chk("c67_busy", bus.busy,               1'b0);
                chk("c67_done", bus.done,               1'b1);
                chk("c67_res",  bus.result_select,      1'b0);
                chk("c67_we",   bus.upper_write_enable, 1'b0);
            end
            if (c == 68) begin
                chk("c68_done", bus.done,          1'b0);
                chk("c68_res",  bus.result_select, 1'b0);
            end
        end
        chk("run1_busy_cycles", busy_cnt, 66);
        chk("run1_done_count",  done_cnt, 1);
        chk("run1_done_cycle",  done_cyc, 67);
        chk("run1_pairs_equal", pair_bad, 0);

        // Second transform with direct_first=0, abandoned by reset at cycle 30.
        bus.start        = 1'b1;
        bus.direct_first = 1'b0;
        done_in_reset    = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            bus.start = 1'b0;
            if (bus.done) done_in_reset++;
            if (c == 1) begin
                chk("run2_c1_is",    bus.input_select, 1'b0);
                chk("run2_c1_busy",  bus.busy,         1'b1);
            end
            if (c == 12) begin
                chk("run2_c12_is",   bus.input_select, 1'b0);
                chk("run2_c12_lm",   bus.log_m,        4'd5);
            end
            if (c == 30) chk("run2_c30_rd", bus.upper_read_address, 9'd7);
        end
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst_");
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.done) done_in_reset++;
        end
        #2 rst_n = 1'b1;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (bus.done || bus.busy) done_in_reset++;
        end
        chk("abandoned_no_done", done_in_reset, 0);

        // Restart after reset: full run from stage 0.
        bus.start = 1'b1;
        got       = 0;
        done_cyc  = -1;
        for (int c = 1; c <= 100 && got == 0; c++) begin
            tick();
            bus.start = 1'b0;
            if (c == 1) begin
                chk("run3_c1_busy",  bus.busy,               1'b1);
                chk("run3_c1_lm",    bus.log_m,              4'd6);
                chk("run3_c1_rd",    bus.upper_read_address, 9'd0);
                chk("run3_c1_ws",    bus.write_select,       1'b1);
            end
            if (bus.done) begin
                got      = 1;
                done_cyc = c;
            end
        end
        chk("run3_done_cycle", done_cyc, 67);
        chk("run3_res",        bus.result_select, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
